// File: rtl/cordic_arb_pkg.sv
// Shared constants and helpers for the CORDIC request arbiter.
package cordic_arb_pkg;

  localparam int ANGLE_W     = 32;
  localparam int DATA_W      = 32;
  localparam int N_REQ_DEF   = 4;
  localparam int MAX_OUT_DEF = 32;

  // Width of a requester id; never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester-side bus of the CORDIC arbiter: request handshake plus routed results.
interface cordic_arbiter_if #(
  parameter int N_REQ   = cordic_arb_pkg::N_REQ_DEF,
  parameter int ANGLE_W = cordic_arb_pkg::ANGLE_W,
  parameter int DATA_W  = cordic_arb_pkg::DATA_W
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*ANGLE_W-1:0] req_angle;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ-1:0]         rsp_valid;
  logic [DATA_W-1:0]        rsp_sin;
  logic [DATA_W-1:0]        rsp_cos;

  modport master (
    output req_valid, req_angle,
    input  req_ready, rsp_valid, rsp_sin, rsp_cos
  );

  modport slave (
    input  req_valid, req_angle,
    output req_ready, rsp_valid, rsp_sin, rsp_cos
  );
endinterface

// File: rtl/cordic_tag_fifo.sv
// In-order FIFO of requester ids for operations in flight through the CORDIC.
// Accepts a push while full provided a pop happens in the same cycle.
module cordic_tag_fifo
  import cordic_arb_pkg::*;
#(
  parameter int ID_W  = 2,
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [ID_W-1:0]         push_id,
  input  logic                    pop,
  output logic [ID_W-1:0]         pop_id,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_id  = mem[rd_ptr];

  // Id storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_id;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one CORDIC pipeline among N_REQ requesters.
// Ids of issued angles ride a tag FIFO so each result returns to its issuer.
module cordic_arbiter #(
  parameter int N_REQ   = cordic_arb_pkg::N_REQ_DEF,
  parameter int ANGLE_W = cordic_arb_pkg::ANGLE_W,
  parameter int DATA_W  = cordic_arb_pkg::DATA_W,
  parameter int MAX_OUT = cordic_arb_pkg::MAX_OUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cordic_arbiter_if.slave           bus,
  output logic [ANGLE_W-1:0]        cor_angle,
  output logic                      cor_pre_vaild,
  input  logic [DATA_W-1:0]         cor_sin,
  input  logic [DATA_W-1:0]         cor_cos,
  input  logic                      cor_post_vaild,
  output logic [$clog2(MAX_OUT):0]  outstanding,
  output logic                      err_orphan
);
  import cordic_arb_pkg::*;

  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic [ID_W-1:0]           rr_ptr;
  logic [N_REQ-1:0]          grant_p0;
  logic [ID_W-1:0]           gnt_id_p0;
  logic signed [ANGLE_W-1:0] sel_angle_p0;
  logic                      found_p0;
  logic                      accept_p0;
  logic                      issue_ok;
  logic                      pop;
  logic [ID_W-1:0]           pop_id;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_empty;
  logic                      fifo_full;

  // A slot frees up when a result pops this cycle, so a full FIFO can still issue.
  assign pop      = cor_post_vaild && !fifo_empty;
  assign issue_ok = !fifo_full || pop;

  // ---- stage p0: combinational round-robin pick, starting at rr_ptr ----
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_p0     = '0;
    gnt_id_p0    = '0;
    sel_angle_p0 = '0;
    found_p0     = 1'b0;
    idx          = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found_p0 && bus.req_valid[idx]) begin
        found_p0     = 1'b1;
        gnt_id_p0    = idx;
        sel_angle_p0 = bus.req_angle[int'(idx)*ANGLE_W +: ANGLE_W];
      end
    end
    if (found_p0 && issue_ok) grant_p0[gnt_id_p0] = 1'b1;
  end

  assign accept_p0     = |grant_p0;
  assign bus.req_ready = grant_p0;

  cordic_tag_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept_p0),
    .push_id (gnt_id_p0),
    .pop     (pop),
    .pop_id  (pop_id),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign outstanding = fifo_count;

  // ---- stage p1: issue register toward the CORDIC; pointer moves past the winner ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      cor_pre_vaild <= 1'b0;
      cor_angle     <= '0;
    end else begin
      cor_pre_vaild <= accept_p0;
      if (accept_p0) begin
        cor_angle <= sel_angle_p0;
        rr_ptr    <= (int'(gnt_id_p0) == N_REQ - 1) ? '0 : gnt_id_p0 + ID_W'(1);
      end
    end
  end

  // ---- response register: route each result to the id at the FIFO head ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= '0;
      bus.rsp_sin   <= '0;
      bus.rsp_cos   <= '0;
      err_orphan    <= 1'b0;
    end else begin
      bus.rsp_valid <= '0;
      if (cor_post_vaild) begin
        if (pop) begin
          bus.rsp_valid <= N_REQ'(1) << pop_id;
          bus.rsp_sin   <= cor_sin;
          bus.rsp_cos   <= cor_cos;
        end else begin
          err_orphan <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: two instances (deep and shallow tag FIFO), each fed by a
// 16-cycle delay-line CORDIC stand-in (sin = angle, cos = ~angle).
module tb_cordic_arbiter;

  localparam int L   = 16;
  localparam int LAT = L + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int peak_a = 0;
  int peak_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          id;
    logic [31:0] s;
    logic [31:0] c;
    int          t;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  cordic_arbiter_if #(.N_REQ(4), .ANGLE_W(32), .DATA_W(32)) bus_a ();
  cordic_arbiter_if #(.N_REQ(4), .ANGLE_W(32), .DATA_W(32)) bus_b ();

  logic [31:0] cor_angle_a, cor_sin_a, cor_cos_a;
  logic        pre_a, post_a, orph_a, inject_a;
  logic [5:0]  out_a;
  logic [31:0] cor_angle_b, cor_sin_b, cor_cos_b;
  logic        pre_b, post_b, orph_b;
  logic [2:0]  out_b;

  cordic_arbiter #(.N_REQ(4), .ANGLE_W(32), .DATA_W(32), .MAX_OUT(32)) dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus_a),
    .cor_angle      (cor_angle_a),
    .cor_pre_vaild  (pre_a),
    .cor_sin        (cor_sin_a),
    .cor_cos        (cor_cos_a),
    .cor_post_vaild (post_a),
    .outstanding    (out_a),
    .err_orphan     (orph_a)
  );

  cordic_arbiter #(.N_REQ(4), .ANGLE_W(32), .DATA_W(32), .MAX_OUT(4)) dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus_b),
    .cor_angle      (cor_angle_b),
    .cor_pre_vaild  (pre_b),
    .cor_sin        (cor_sin_b),
    .cor_cos        (cor_cos_b),
    .cor_post_vaild (post_b),
    .outstanding    (out_b),
    .err_orphan     (orph_b)
  );

  // CORDIC stand-ins: fixed-latency delay lines sharing rst_n.
  logic [L-1:0] sv_a, sv_b;
  logic [31:0]  sa_a [L];
  logic [31:0]  sa_b [L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sv_a <= '0;
      sv_b <= '0;
    end else begin
      sv_a <= {sv_a[L-2:0], pre_a};
      sv_b <= {sv_b[L-2:0], pre_b};
    end
  end

  always_ff @(posedge clk) begin
    sa_a[0] <= cor_angle_a;
    sa_b[0] <= cor_angle_b;
    for (int i = 1; i < L; i++) begin
      sa_a[i] <= sa_a[i-1];
      sa_b[i] <= sa_b[i-1];
    end
  end

  assign post_a    = sv_a[L-1] | inject_a;
  assign cor_sin_a = sa_a[L-1];
  assign cor_cos_a = ~sa_a[L-1];
  assign post_b    = sv_b[L-1];
  assign cor_sin_b = sa_b[L-1];
  assign cor_cos_b = ~sa_b[L-1];

  // Scoreboard for instance A: push on acceptance, pop and compare on each response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_a.req_valid[i] && bus_a.req_ready[i]) begin
          e.id = i;
          e.s  = bus_a.req_angle[i*32 +: 32];
          e.c  = ~e.s;
          e.t  = cyc;
          q_a.push_back(e);
        end
      end
      if (int'(out_a) > peak_a) peak_a = int'(out_a);
      if (bus_a.rsp_valid !== 4'b0000) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL rsp_a_unexpected: rsp_valid=%b, required no response", bus_a.rsp_valid);
        end else begin
          e = q_a.pop_front();
          if (bus_a.rsp_valid !== 4'(1 << e.id) || bus_a.rsp_sin !== e.s ||
              bus_a.rsp_cos !== e.c || (cyc - e.t) != LAT) begin
            errors++;
            $display("FAIL rsp_a: valid=%b sin=%h cos=%h lat=%0d, required valid=%b sin=%h cos=%h lat=%0d",
                     bus_a.rsp_valid, bus_a.rsp_sin, bus_a.rsp_cos, cyc - e.t,
                     4'(1 << e.id), e.s, e.c, LAT);
          end
        end
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (bus_b.req_valid[i] && bus_b.req_ready[i]) begin
          e.id = i;
          e.s  = bus_b.req_angle[i*32 +: 32];
          e.c  = ~e.s;
          e.t  = cyc;
          q_b.push_back(e);
        end
      end
      if (int'(out_b) > peak_b) peak_b = int'(out_b);
      if (bus_b.rsp_valid !== 4'b0000) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL rsp_b_unexpected: rsp_valid=%b, required no response", bus_b.rsp_valid);
        end else begin
          e = q_b.pop_front();
          if (bus_b.rsp_valid !== 4'(1 << e.id) || bus_b.rsp_sin !== e.s ||
              bus_b.rsp_cos !== e.c || (cyc - e.t) != LAT) begin
            errors++;
            $display("FAIL rsp_b: valid=%b sin=%h cos=%h lat=%0d, required valid=%b sin=%h cos=%h lat=%0d",
                     bus_b.rsp_valid, bus_b.rsp_sin, bus_b.rsp_cos, cyc - e.t,
                     4'(1 << e.id), e.s, e.c, LAT);
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus_a.req_valid = '0;
    bus_b.req_valid = '0;
    inject_a = 1'b0;
    q_a.delete();
    q_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    peak_a = 0;
    peak_b = 0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending a=%0d b=%0d, required 0 0", name, q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus_a.req_ready, pre_a, cor_angle_a} !== '0) begin
      errors++;
      $display("FAIL reset_issue_a: ready=%b pre=%b angle=%h, required 0", bus_a.req_ready, pre_a, cor_angle_a);
    end
    checks++;
    if ({bus_a.rsp_valid, bus_a.rsp_sin, bus_a.rsp_cos} !== '0) begin
      errors++;
      $display("FAIL reset_rsp_a: valid=%b sin=%h cos=%h, required 0", bus_a.rsp_valid, bus_a.rsp_sin, bus_a.rsp_cos);
    end
    checks++;
    if (out_a !== 6'd0 || orph_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: outstanding=%0d err_orphan=%b, required 0 0", out_a, orph_a);
    end
    checks++;
    if ({pre_b, cor_angle_b, bus_b.rsp_valid, out_b, orph_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: pre=%b angle=%h rsp=%b out=%0d orph=%b, required 0", pre_b, cor_angle_b, bus_b.rsp_valid, out_b, orph_b);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    bus_a.req_angle = '0;
    bus_a.req_angle[31:0] = 32'(60 * 65536);
    bus_a.req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (bus_a.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready: ready=%b, required 0001", bus_a.req_ready);
    end
    @(posedge clk);
    #1;
    bus_a.req_valid = '0;
    @(negedge clk);
    checks++;
    if (pre_a !== 1'b1 || cor_angle_a !== 32'h003C0000) begin
      errors++;
      $display("FAIL single_issue: pre=%b angle=%h, required 1 003c0000", pre_a, cor_angle_a);
    end
    @(negedge clk);
    checks++;
    if (pre_a !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: pre=%b, required 0", pre_a);
    end
    wait_drain("single");
  endtask

  task automatic test_all_four();
    apply_reset();
    bus_a.req_angle = {32'(120 * 65536), 32'(90 * 65536), 32'(60 * 65536), 32'(30 * 65536)};
    bus_a.req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (bus_a.req_ready !== 4'(1 << (i % 4))) begin
        errors++;
        $display("FAIL rr_order[%0d]: ready=%b, required %b", i, bus_a.req_ready, 4'(1 << (i % 4)));
      end
      @(posedge clk);
      #1;
    end
    bus_a.req_valid = '0;
    wait_drain("all_four");
    checks++;
    if (peak_a != 8) begin
      errors++;
      $display("FAIL all_four_peak: outstanding peak=%0d, required 8", peak_a);
    end
  endtask

  task automatic test_saturation();
    int acc = 0;
    apply_reset();
    bus_b.req_angle = {32'(-45 * 65536), 32'(15 * 65536), 32'(170 * 65536), 32'(5 * 65536)};
    bus_b.req_valid = 4'b1111;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (|(bus_b.req_valid & bus_b.req_ready)) acc++;
      if (i == 3 || i == 17) begin
        checks++;
        if (bus_b.req_ready === 4'b0000) begin
          errors++;
          $display("FAIL sat_ready_on[%0d]: ready=%b, required a grant", i, bus_b.req_ready);
        end
      end
      if (i == 4 || i == 16) begin
        checks++;
        if (bus_b.req_ready !== 4'b0000) begin
          errors++;
          $display("FAIL sat_ready_off[%0d]: ready=%b out=%0d, required 0000", i, bus_b.req_ready, out_b);
        end
      end
      @(posedge clk);
      #1;
    end
    bus_b.req_valid = '0;
    checks++;
    if (acc != 16) begin
      errors++;
      $display("FAIL sat_accepts: accepted=%0d, required 16", acc);
    end
    wait_drain("saturation");
    checks++;
    if (peak_b != 4) begin
      errors++;
      $display("FAIL sat_peak: outstanding peak=%0d, required 4", peak_b);
    end
  endtask

  task automatic test_orphan();
    apply_reset();
    inject_a = 1'b1;
    @(posedge clk);
    #1;
    inject_a = 1'b0;
    @(negedge clk);
    checks++;
    if (orph_a !== 1'b1 || bus_a.rsp_valid !== 4'b0000 || out_a !== 6'd0) begin
      errors++;
      $display("FAIL orphan_set: err=%b rsp=%b out=%0d, required 1 0000 0", orph_a, bus_a.rsp_valid, out_a);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (orph_a !== 1'b1 || orph_b !== 1'b0) begin
      errors++;
      $display("FAIL orphan_sticky: err_a=%b err_b=%b, required 1 0", orph_a, orph_b);
    end
  endtask

  task automatic test_reset_midflight();
    int stray = 0;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      bus_a.req_angle[(k % 4)*32 +: 32] = 32'(-(30 * (k + 1)) * 65536);
      bus_a.req_valid = 4'(1 << (k % 4));
      @(posedge clk);
      #1;
    end
    bus_a.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q_a.delete();
    @(negedge clk);
    checks++;
    if ({pre_a, cor_angle_a, bus_a.rsp_valid, bus_a.rsp_sin, bus_a.rsp_cos, out_a, orph_a} !== '0) begin
      errors++;
      $display("FAIL midflight_reset: pre=%b angle=%h rsp=%b out=%0d orph=%b, required 0",
               pre_a, cor_angle_a, bus_a.rsp_valid, out_a, orph_a);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_a.rsp_valid !== 4'b0000) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL midflight_stale: stray responses=%0d, required 0", stray);
    end
    @(posedge clk);
    #1;
    bus_a.req_angle[63:32] = 32'(45 * 65536);
    bus_a.req_valid = 4'b0010;
    @(posedge clk);
    #1;
    bus_a.req_valid = '0;
    checks++;
    if (q_a.size() != 1) begin
      errors++;
      $display("FAIL midflight_new_issue: queued=%0d, required 1", q_a.size());
    end
    wait_drain("midflight_new");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus_a.req_valid = '0;
    bus_a.req_angle = '0;
    bus_b.req_valid = '0;
    bus_b.req_angle = '0;
    inject_a = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_saturation();
    test_orphan();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
Name: cordic_arbiter

Overview:
Shares one `cordic_sin_cos` pipeline (PIPELINE=16) between N independent requesters. It grants one angle per cycle round-robin and drives the CORDIC input. Requester IDs are kept in order in a tag FIFO, and each CORDIC result is routed back to the requester that issued it. It sits between the requester blocks and `cordic_sin_cos` on the same `clk`/`rst_n`.

Parameters:
N_REQ, 4, number of requesters (2..8)
ANGLE_W, 32, angle width, signed Q16.16 degrees
DATA_W, 32, sin/cos width, signed
MAX_OUT, 32, max in-flight operations (tag FIFO depth, power of 2, must be >= CORDIC latency + 2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_angle  in  N_REQ*ANGLE_W  packed angles; requester i uses bits [i*ANGLE_W +: ANGLE_W]
req_ready  out  N_REQ  one-hot grant; a request is accepted when valid & ready
cor_angle  out  ANGLE_W  angle to CORDIC
cor_pre_vaild  out  1  CORDIC input valid
cor_sin  in  DATA_W  CORDIC sin result
cor_cos  in  DATA_W  CORDIC cos result
cor_post_vaild  in  1  CORDIC output valid
rsp_valid  out  N_REQ  one-hot response strobe
rsp_sin  out  DATA_W  routed sin result
rsp_cos  out  DATA_W  routed cos result
outstanding  out  $clog2(MAX_OUT)+1  number of in-flight operations
err_orphan  out  1  sticky error: cor_post_vaild arrived while the tag FIFO was empty

Behaviour:
- Reset (async, rst_n=0): every output is 0; RR pointer = 0; tag FIFO empty; count = 0; err_orphan = 0.
- Reset mid-operation: all in-flight tags are dropped. The CORDIC shares rst_n, so no stale results return afterwards.
- Arbitration (combinational):
  - Round-robin among req_valid; requester at the RR pointer has highest priority.
  - req_ready is one-hot or zero and depends on req_valid.
  - Issue is allowed when count < MAX_OUT, or when count == MAX_OUT and a pop happens in the same cycle.
  - If issue is not allowed, req_ready = 0.
- On accepting requester g:
  - RR pointer <= (g+1) mod N_REQ; the pointer is unchanged on idle cycles.
  - Registered: cor_pre_vaild <= 1, cor_angle <= req_angle[g], and g is pushed into the tag FIFO.
  - If nothing is accepted, cor_pre_vaild <= 0 and cor_angle holds its previous value.
- No stall path: the CORDIC pipeline cannot back-pressure, and requesters must always accept responses.
- Response (registered, 1 cycle after cor_post_vaild = 1):
  - If the FIFO is non-empty: pop the head id h; rsp_valid <= onehot(h); rsp_sin/rsp_cos <= cor_sin/cor_cos.
  - If the FIFO is empty: rsp_valid <= 0 and err_orphan <= 1. It stays set until reset.
  - When cor_post_vaild = 0, rsp_valid <= 0 and rsp_sin/rsp_cos hold their values.
- Latency: acceptance edge -> rsp_valid = L_cordic + 2 cycles, where L_cordic is the CORDIC pre_vaild-to-post_vaild latency.
- Throughput: 1 operation per cycle in aggregate. Results return in issue order.
- Count:
  - +1 on push only, -1 on pop only, unchanged when push and pop occur together.
  - outstanding = count. FIFO pointers wrap modulo MAX_OUT.
- Arithmetic: angles and results pass through unmodified (no scaling, no quadrant folding).

Decomposition:
- Package `cordic_arb_pkg`: ANGLE_W, DATA_W, default N_REQ/MAX_OUT, and an id-width function ($clog2(N_REQ), minimum 1).
- Sub-module `cordic_tag_fifo`: synchronous FIFO of ids, depth MAX_OUT, with push/pop/count/empty/full. It must support push and pop in the same cycle when full.
- The top level holds the RR arbiter, the issue register and the response demux.

Test Plan:
- Bench: real `cordic_sin_cos` plus a delay-line stub model (sin = angle, cos = ~angle, latency 16), so routing can be checked bit-exactly.
- Single request: req0 angle 60*65536, no other requests.
  - Expect cor_pre_vaild for 1 cycle with cor_angle = 0x003C0000.
  - Expect rsp_valid = 4'b0001 exactly L+2 cycles later.
  - With the stub, rsp_sin = 0x003C0000.
- All four requesters held valid for 8 cycles, angles 30/60/90/120 * 65536:
  - Grant order is 0,1,2,3,0,1,2,3.
  - Responses return in the same order with matching payloads; outstanding peaks at 8.
- Saturation: run with MAX_OUT=4 and stub latency 16, requesters continuously valid.
  - req_ready drops once 4 operations are in flight.
  - Issue then proceeds only on pop cycles; no response is lost; outstanding never exceeds 4.
- Orphan result: with nothing issued, force the stub's cor_post_vaild = 1 for 1 cycle.
  - Expect err_orphan = 1 and it stays set; rsp_valid stays 0.
- Reset mid-flight: issue 5 requests (angles -30..-150 * 65536), then assert rst_n = 0 for 2 cycles.
  - All outputs are 0 and outstanding = 0.
  - No rsp_valid appears afterwards; a new request after reset completes normally with latency L+2.
